// File: rtl/adbg_pkg.sv
// Shared types and defaults for the CPU-side debug bridge.
package adbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_ACK    = 3'd3,
    ST_DRAIN  = 3'd4
  } dbg_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // A disabled timeout (0) still needs a legal one-bit counter.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/adbg_cpu_dbg_fsm.sv
// One core's slave FSM: BIU strobe bus in, req/gnt/rvalid debug port out,
// with a saturating per-transaction timeout so the BIU always gets an ack.
module adbg_cpu_dbg_fsm
  import adbg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        req_o,
  output logic        dbg_we_o,
  output logic [15:0] dbg_addr_o,
  output logic [31:0] dbg_wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  localparam int          CW        = cnt_width(TIMEOUT_CYCLES);
  localparam bit          TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  dbg_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic          ack_q, ack_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          to_q, to_d;
  logic          expired;

  // The counter is not cleared on REQ->WAIT_R, so a gnt that wins the
  // expiry cycle leaves WAIT_R a single cycle to see rvalid.
  assign expired = TO_EN && (cnt_q >= CNT_LIMIT);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    to_d    = to_q & ~timeout_clr_i;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (stb_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_R;
        end else if (expired) begin
          req_d   = 1'b0;
          data_d  = ERR_DATA;
          ack_d   = 1'b1;
          to_d    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_WAIT_R: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (rvalid_i) begin
          data_d  = we_q ? 32'h0 : rdata_i;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (expired) begin
          data_d  = ERR_DATA;
          ack_d   = 1'b1;
          to_d    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = stb_i ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!stb_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_o      = data_q;
  assign ack_o       = ack_q;
  assign req_o       = req_q;
  assign dbg_we_o    = we_q;
  assign dbg_addr_o  = addr_q;
  assign dbg_wdata_o = wdata_q;
  assign timeout_o   = to_q;

endmodule

// File: rtl/adbg_cpu_dbg_bridge.sv
// CPU-clock-domain bridge between the debug BIU strobe bus and per-core
// req/gnt/rvalid debug ports; one independent FSM per core.
module adbg_cpu_dbg_bridge
  import adbg_pkg::*;
#(
  parameter int          NB_CORES       = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                  cpu_clk_i,
  input  logic                  cpu_rstn_i,
  input  logic [NB_CORES*16-1:0] cpu_addr_i,
  input  logic [NB_CORES*32-1:0] cpu_data_i,
  input  logic [NB_CORES-1:0]    cpu_stb_i,
  input  logic [NB_CORES-1:0]    cpu_we_i,
  output logic [NB_CORES*32-1:0] cpu_data_o,
  output logic [NB_CORES-1:0]    cpu_ack_o,
  output logic [NB_CORES-1:0]    dbg_req_o,
  output logic [NB_CORES-1:0]    dbg_we_o,
  output logic [NB_CORES*16-1:0] dbg_addr_o,
  output logic [NB_CORES*32-1:0] dbg_wdata_o,
  input  logic [NB_CORES-1:0]    dbg_gnt_i,
  input  logic [NB_CORES-1:0]    dbg_rvalid_i,
  input  logic [NB_CORES*32-1:0] dbg_rdata_i,
  output logic [NB_CORES-1:0]    timeout_o,
  input  logic [NB_CORES-1:0]    timeout_clr_i
);

  for (genvar c = 0; c < NB_CORES; c++) begin : g_core
    adbg_cpu_dbg_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .ERR_DATA       (ERR_DATA)
    ) u_fsm (
      .clk_i         (cpu_clk_i),
      .rstn_i        (cpu_rstn_i),
      .addr_i        (cpu_addr_i[c*16 +: 16]),
      .wdata_i       (cpu_data_i[c*32 +: 32]),
      .stb_i         (cpu_stb_i[c]),
      .we_i          (cpu_we_i[c]),
      .data_o        (cpu_data_o[c*32 +: 32]),
      .ack_o         (cpu_ack_o[c]),
      .req_o         (dbg_req_o[c]),
      .dbg_we_o      (dbg_we_o[c]),
      .dbg_addr_o    (dbg_addr_o[c*16 +: 16]),
      .dbg_wdata_o   (dbg_wdata_o[c*32 +: 32]),
      .gnt_i         (dbg_gnt_i[c]),
      .rvalid_i      (dbg_rvalid_i[c]),
      .rdata_i       (dbg_rdata_i[c*32 +: 32]),
      .timeout_o     (timeout_o[c]),
      .timeout_clr_i (timeout_clr_i[c])
    );
  end

endmodule

// File: tb/tb_adbg_cpu_dbg_bridge.sv
// Directed bench for adbg_cpu_dbg_bridge: per-cycle vector table plus
// hand-written timeout, drain, concurrency and reset sequences.
module tb_adbg_cpu_dbg_bridge;
  import adbg_pkg::*;

  localparam int NB = 4;
  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NB*16-1:0]   cpu_addr;
  logic [NB*32-1:0]   cpu_wdata;
  logic [NB-1:0]      stb, we;
  logic [NB*32-1:0]   cpu_rdata;
  logic [NB-1:0]      ack, req, dwe;
  logic [NB*16-1:0]   daddr;
  logic [NB*32-1:0]   dwdata;
  logic [NB-1:0]      gnt, rvalid;
  logic [NB*32-1:0]   rdata;
  logic [NB-1:0]      tout, tclr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adbg_cpu_dbg_bridge #(.NB_CORES(NB), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .cpu_clk_i     (clk),
    .cpu_rstn_i    (rstn),
    .cpu_addr_i    (cpu_addr),
    .cpu_data_i    (cpu_wdata),
    .cpu_stb_i     (stb),
    .cpu_we_i      (we),
    .cpu_data_o    (cpu_rdata),
    .cpu_ack_o     (ack),
    .dbg_req_o     (req),
    .dbg_we_o      (dwe),
    .dbg_addr_o    (daddr),
    .dbg_wdata_o   (dwdata),
    .dbg_gnt_i     (gnt),
    .dbg_rvalid_i  (rvalid),
    .dbg_rdata_i   (rdata),
    .timeout_o     (tout),
    .timeout_clr_i (tclr)
  );

  typedef struct {
    int          core;
    logic        stb, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ack;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(int core, logic s, logic w, logic [15:0] a, logic [31:0] wd,
                               logic g, logic r, logic [31:0] rd, logic erq, logic ewe,
                               logic [15:0] ea, logic [31:0] ewd, logic eak, logic [31:0] ed);
    vec_t v;
    v.core = core; v.stb = s; v.we = w; v.addr = a; v.wdata = wd;
    v.gnt = g; v.rv = r; v.rdata = rd;
    v.e_req = erq; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd; v.e_ack = eak; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_addr = '0; cpu_wdata = '0; stb = '0; we = '0;
    gnt = '0; rvalid = '0; rdata = '0; tclr = '0;
  endtask

  task automatic drive(input int c, input logic s, input logic w, input logic [15:0] a,
                       input logic [31:0] wd, input logic g, input logic r, input logic [31:0] rd);
    stb[c] = s; we[c] = w; cpu_addr[c*16 +: 16] = a; cpu_wdata[c*32 +: 32] = wd;
    gnt[c] = g; rvalid[c] = r; rdata[c*32 +: 32] = rd;
  endtask

  initial begin
    int k, ack0_at, ack3_at, n_ack0, n_ack3;
    bit found;

    // core0 read: gnt 2 cycles after req, rvalid 3 cycles after gnt
    vecs.push_back(mkv(0,1,0,16'h0010,0, 0,0,0,          1,0,16'h0010,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,16'h0010,0, 0,0,0,          1,0,16'h0010,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,16'h0010,0, 0,0,0,          1,0,16'h0010,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,16'h0010,0, 1,0,0,          0,0,16'h0010,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,16'h0010,0, 0,0,0,          0,0,16'h0010,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,16'h0010,0, 0,0,0,          0,0,16'h0010,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,16'h0010,0, 0,1,32'h12345678, 0,0,16'h0010,0,1,32'h12345678));
    vecs.push_back(mkv(0,0,0,16'h0000,0, 0,0,0,          0,0,16'h0010,0,0,32'h12345678));
    // core1 write, gnt in the first req cycle; rdata must be ignored for writes
    vecs.push_back(mkv(1,1,1,16'h0020,32'hA5A5A5A5, 0,0,0, 1,1,16'h0020,32'hA5A5A5A5,0,32'h0));
    vecs.push_back(mkv(1,1,1,16'h0020,32'hA5A5A5A5, 1,0,0, 0,1,16'h0020,32'hA5A5A5A5,0,32'h0));
    vecs.push_back(mkv(1,1,1,16'h0020,32'hA5A5A5A5, 0,1,32'hFFFFFFFF, 0,1,16'h0020,32'hA5A5A5A5,1,32'h0));
    vecs.push_back(mkv(1,0,0,16'h0000,0, 0,0,0,          0,1,16'h0020,32'hA5A5A5A5,0,32'h0));
    // core0: gnt and rvalid together in REQ, only the later rvalid counts
    vecs.push_back(mkv(0,1,0,16'h0030,0, 0,0,0,          1,0,16'h0030,0,0,32'h12345678));
    vecs.push_back(mkv(0,1,0,16'h0030,0, 1,1,32'h0BADF00D, 0,0,16'h0030,0,0,32'h12345678));
    vecs.push_back(mkv(0,1,0,16'h0030,0, 0,1,32'h0000BEEF, 0,0,16'h0030,0,1,32'h0000BEEF));
    vecs.push_back(mkv(0,0,0,16'h0000,0, 0,0,0,          0,0,16'h0030,0,0,32'h0000BEEF));

    clear_inputs();
    rstn = 1'b0;
    step(); step();
    chk("rst_req", req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", cpu_rdata, 0);
    chk("rst_timeout", tout, 0);
    chk("rst_addr", daddr, 0);
    rstn = 1'b1;
    step();

    foreach (vecs[i]) begin
      vec_t v = vecs[i];
      int c = v.core;
      clear_inputs();
      drive(c, v.stb, v.we, v.addr, v.wdata, v.gnt, v.rv, v.rdata);
      step();
      chk($sformatf("vec%0d_req", i), req[c], v.e_req);
      chk($sformatf("vec%0d_we", i), dwe[c], v.e_we);
      chk($sformatf("vec%0d_addr", i), daddr[c*16 +: 16], v.e_addr);
      chk($sformatf("vec%0d_wdata", i), dwdata[c*32 +: 32], v.e_wdata);
      chk($sformatf("vec%0d_ack", i), ack[c], v.e_ack);
      chk($sformatf("vec%0d_data", i), cpu_rdata[c*32 +: 32], v.e_data);
    end
    clear_inputs();
    step();

    // timeout on core2: no gnt at all
    drive(2, 1, 0, 16'h0040, 0, 0, 0, 0);
    step();
    chk("t3_req", req[2], 1);
    k = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      step();
      if (ack[2]) begin found = 1; k = i; end
    end
    chk("t3_ack_latency", k, TO);
    chk("t3_err_data", cpu_rdata[64 +: 32], 32'hDEADBEEF);
    chk("t3_timeout_set", tout[2], 1);
    chk("t3_req_dropped", req[2], 0);
    stb[2] = 1'b0;
    step(); step();
    chk("t3_timeout_sticky", tout[2], 1);
    chk("t3_no_extra_ack", ack[2], 0);

    // second timeout with clear held high: clear acts first, set wins at expiry
    tclr[2] = 1'b1;
    stb[2]  = 1'b1;
    step();
    step();
    chk("t3b_cleared", tout[2], 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ack[2]) found = 1;
    end
    chk("t3b_acked", found, 1);
    chk("t3b_set_wins", tout[2], 1);
    tclr[2] = 1'b0; stb[2] = 1'b0;
    step();
    chk("t3b_still_set", tout[2], 1);
    tclr[2] = 1'b1;
    step();
    chk("t3b_clr", tout[2], 0);
    tclr[2] = 1'b0;
    step();

    // gnt in the expiry cycle beats the timeout
    drive(2, 1, 0, 16'h0044, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 7; i++) step();
    chk("t3c_no_early_ack", ack[2], 0);
    gnt[2] = 1'b1;
    step();
    chk("t3c_gnt_wins_ack", ack[2], 0);
    chk("t3c_gnt_wins_to", tout[2], 0);
    gnt[2] = 1'b0; rvalid[2] = 1'b1; rdata[64 +: 32] = 32'h22220002;
    step();
    chk("t3c_ack", ack[2], 1);
    chk("t3c_data", cpu_rdata[64 +: 32], 32'h22220002);
    chk("t3c_to", tout[2], 0);
    clear_inputs();
    step();

    // stb held past ack: no second request until stb toggles
    drive(0, 1, 0, 16'h0050, 0, 0, 0, 0);
    step();
    gnt[0] = 1'b1;
    step();
    gnt[0] = 1'b0; rvalid[0] = 1'b1; rdata[31:0] = 32'h44440004;
    step();
    chk("t4_ack", ack[0], 1);
    rvalid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_no_req%0d", i), req[0] | ack[0], 0);
    end
    stb[0] = 1'b0;
    step();
    chk("t4_idle", req[0], 0);
    stb[0] = 1'b1;
    step();
    chk("t4_new_req", req[0], 1);
    gnt[0] = 1'b1;
    step();
    gnt[0] = 1'b0; rvalid[0] = 1'b1; rdata[31:0] = 32'h55550005;
    step();
    chk("t4_new_ack", ack[0], 1);
    clear_inputs();
    step();

    // concurrent reads on cores 0 and 3
    drive(0, 1, 0, 16'h0060, 0, 0, 0, 32'h5A5A0000);
    drive(3, 1, 0, 16'h0063, 0, 0, 0, 32'h33330003);
    ack0_at = -1; ack3_at = -1; n_ack0 = 0; n_ack3 = 0;
    for (int e = 0; e <= 10; e++) begin
      gnt[0] = (e == 1); rvalid[0] = (e == 2);
      gnt[3] = (e == 3); rvalid[3] = (e == 6);
      step();
      if (ack[0]) begin n_ack0++; ack0_at = e; end
      if (ack[3]) begin n_ack3++; ack3_at = e; end
    end
    chk("t5_ack0_time", ack0_at, 2);
    chk("t5_ack3_time", ack3_at, 6);
    chk("t5_ack0_count", n_ack0, 1);
    chk("t5_ack3_count", n_ack3, 1);
    chk("t5_data0", cpu_rdata[0 +: 32], 32'h5A5A0000);
    chk("t5_data3", cpu_rdata[96 +: 32], 32'h33330003);
    clear_inputs();
    step();

    // reset while core1 waits for rvalid
    drive(1, 1, 0, 16'h0070, 0, 0, 0, 0);
    step();
    gnt[1] = 1'b1;
    step();
    gnt[1] = 1'b0; stb[1] = 1'b0; rstn = 1'b0;
    step();
    chk("t6_req", req, 0);
    chk("t6_ack", ack, 0);
    chk("t6_data", cpu_rdata, 0);
    chk("t6_addr", daddr, 0);
    chk("t6_wdata", dwdata, 0);
    chk("t6_we", dwe, 0);
    chk("t6_timeout", tout, 0);
    rstn = 1'b1;
    rvalid[1] = 1'b1; rdata[32 +: 32] = 32'h77770007;
    n_ack0 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack[1]) n_ack0++;
    end
    chk("t6_no_late_ack", n_ack0, 0);
    chk("t6_data_zero", cpu_rdata[32 +: 32], 0);
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
